// File: rtl/seq_det_param.sv
// -----------------------------------------------------------------------------
// seq_det_param
//
// Parametrised serial bit-sequence detector. Bits arrive MSB-of-pattern first
// on din; every accepted bit advances a KMP-style state machine whose
// next-state table is built at elaboration. A completed pattern raises a
// one-cycle match pulse (combinational or registered), bumps a saturating
// match counter, and the current number of matched prefix bits is exposed on
// progress.
//
// All registers update on the FALLING edge of clk; rst_n is asynchronous and
// active low.
//
// Parameters
//   PAT_LEN   pattern length in bits (2..16)
//   PATTERN   pattern; bit PAT_LEN-1 is compared with the first received bit
//   OVERLAP   1: matches may share bits, 0: search restarts after a match
//   REG_OUT   0: match is combinational (Mealy), 1: match registered (+1 cycle)
//   CNT_W     width of match_cnt
//
// Ports
//   clk        in   clock (falling-edge active)
//   rst_n      in   asynchronous active-low reset
//   en         in   1: din accepted this cycle, 0: all state holds
//   din        in   serial data bit
//   clr_cnt    in   synchronous clear of match_cnt (wins over an increment)
//   match      out  one pulse per detected pattern
//   match_cnt  out  saturating match count
//   progress   out  number of pattern bits currently matched
// -----------------------------------------------------------------------------
module seq_det_param #(
    parameter int unsigned          PAT_LEN = 5,
    parameter logic [PAT_LEN-1:0]   PATTERN = 5'b10010,
    parameter bit                   OVERLAP = 1'b1,
    parameter bit                   REG_OUT = 1'b0,
    parameter int unsigned          CNT_W   = 8,
    localparam int unsigned         PROG_W  = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              din,
    input  logic              clr_cnt,
    output logic              match,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [PROG_W-1:0] progress
);

    // -------------------------------------------------------------------------
    // Elaboration-time checks
    // -------------------------------------------------------------------------
    if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_len
        $error("seq_det_param: PAT_LEN must be in 2..16");
    end

    // -------------------------------------------------------------------------
    // Next-state function, evaluated only with constant arguments.
    // The accepted history in state s is the first s pattern bits; appending
    // b gives a string of length s+1. The next state is the longest pattern
    // prefix (shorter than the whole pattern) that is also a suffix of it.
    // On a full match this yields the longest proper border, which is the
    // overlap restart point; non-overlap mode forces 0 instead.
    // -------------------------------------------------------------------------
    function automatic logic [PROG_W-1:0] kmp_next(input int s, input logic b);
        int   len;
        int   best;
        int   pos;
        logic ok;
        logic seq_bit;
        len  = s + 1;
        best = 0;
        for (int k = 1; k <= len; k++) begin
            if (k < int'(PAT_LEN)) begin
                ok = 1'b1;
                for (int i = 0; i < k; i++) begin
                    pos     = len - k + i;
                    seq_bit = (pos < s) ? PATTERN[int'(PAT_LEN) - 1 - pos] : b;
                    if (seq_bit != PATTERN[int'(PAT_LEN) - 1 - i]) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    best = k;
                end
            end
        end
        if (!OVERLAP && (s == int'(PAT_LEN) - 1) && (b == PATTERN[0])) begin
            best = 0;
        end
        return PROG_W'(best);
    endfunction

    // Constant lookup tables, one entry per state for each value of din.
    logic [PROG_W-1:0] next_on0 [PAT_LEN];
    logic [PROG_W-1:0] next_on1 [PAT_LEN];

    for (genvar g = 0; g < PAT_LEN; g++) begin : g_next
        localparam logic [PROG_W-1:0] NEXT_ON0 = kmp_next(g, 1'b0);
        localparam logic [PROG_W-1:0] NEXT_ON1 = kmp_next(g, 1'b1);
        assign next_on0[g] = NEXT_ON0;
        assign next_on1[g] = NEXT_ON1;
    end

    // -------------------------------------------------------------------------
    // State machine
    // -------------------------------------------------------------------------
    logic [PROG_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              at_last;
    logic              hit;

    always_comb begin
        at_last = (state_q == PROG_W'(PAT_LEN - 1));
        // rst_n gating keeps the Mealy output quiet for the whole reset window.
        hit     = en & rst_n & at_last & (din == PATTERN[0]);

        state_d = state_q;
        if (en) begin
            state_d = din ? next_on1[state_q] : next_on0[state_q];
        end

        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    if (REG_OUT) begin : g_reg_out
        logic match_q;

        // Holds while en is low so a pending pulse is not lost on a stall.
        always_ff @(negedge clk or negedge rst_n) begin
            if (!rst_n) begin
                match_q <= 1'b0;
            end else if (en) begin
                match_q <= hit;
            end
        end

        assign match = match_q;
    end else begin : g_comb_out
        assign match = hit;
    end

    assign match_cnt = cnt_q;
    assign progress  = state_q;

endmodule
